// File: rtl/draw_scheduler_pkg.sv
// Shared definitions for the draw scheduler: FSM states, widths, drawer timing and board geometry.
package draw_scheduler_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_BOARD = 3'd1,
    S_GAP   = 3'd2,
    S_ERASE = 3'd3,
    S_DRAW  = 3'd4,
    S_FIN   = 3'd5
  } state_t;

  localparam int X_W             = 8;
  localparam int Y_W             = 7;
  localparam int COLOUR_W        = 6;
  localparam int PHASE_W         = 13;
  localparam int TET_CYCLES_DEF  = 64;
  localparam int WDOG_CYCLES_DEF = 8191;
  localparam int BOARD_COLS      = 10;
  localparam int BOARD_ROWS      = 25;

  typedef struct packed {
    logic [2:0] block;
    logic [1:0] rot;
    logic [4:0] x;
    logic [5:0] y;
  } piece_t;

endpackage

// File: rtl/draw_mux.sv
// Selects the active drawer's pixel stream onto the VGA write port and derives the plot strobe.
module draw_mux
  import draw_scheduler_pkg::*;
#(
  parameter int TET_CYCLES = TET_CYCLES_DEF
) (
  input  state_t              state,
  input  logic [PHASE_W-1:0]  phase,
  input  logic [X_W-1:0]      brd_x,
  input  logic [Y_W-1:0]      brd_y,
  input  logic [COLOUR_W-1:0] brd_colour,
  input  logic [X_W-1:0]      tet_vx,
  input  logic [Y_W-1:0]      tet_vy,
  input  logic [COLOUR_W-1:0] tet_colour,
  output logic [X_W-1:0]      vga_x,
  output logic [Y_W-1:0]      vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                vga_plot
);

  // Drawer outputs are registered, so phase 0 of every pass carries no valid pixel.
  always_comb begin
    vga_x      = '0;
    vga_y      = '0;
    vga_colour = '0;
    vga_plot   = 1'b0;
    case (state)
      S_BOARD: begin
        vga_x      = brd_x;
        vga_y      = brd_y;
        vga_colour = brd_colour;
        vga_plot   = (phase != '0);
      end
      S_ERASE, S_DRAW: begin
        vga_x      = tet_vx;
        vga_y      = tet_vy;
        vga_colour = tet_colour;
        vga_plot   = (phase != '0) && (phase <= PHASE_W'(TET_CYCLES));
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/draw_scheduler.sv
// Owns the single VGA write port: serialises board redraws and piece erase/draw passes,
// with a per-phase watchdog and a shadow copy of the last piece actually drawn.
module draw_scheduler
  import draw_scheduler_pkg::*;
#(
  parameter int WDOG_CYCLES = WDOG_CYCLES_DEF,
  parameter int TET_CYCLES  = TET_CYCLES_DEF
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                board_req,
  input  logic                piece_req,
  input  logic [2:0]          piece_block,
  input  logic [1:0]          piece_rot,
  input  logic [4:0]          piece_x,
  input  logic [5:0]          piece_y,
  output logic                ack,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic                brd_en,
  input  logic [X_W-1:0]      brd_x,
  input  logic [Y_W-1:0]      brd_y,
  input  logic [COLOUR_W-1:0] brd_colour,
  input  logic                brd_complete,
  output logic                tet_en,
  output logic                tet_clear,
  output logic [2:0]          tet_block,
  output logic [1:0]          tet_rot,
  output logic [4:0]          tet_x,
  output logic [5:0]          tet_y,
  input  logic [X_W-1:0]      tet_vx,
  input  logic [Y_W-1:0]      tet_vy,
  input  logic [COLOUR_W-1:0] tet_colour,
  input  logic                tet_complete,
  output logic [X_W-1:0]      vga_x,
  output logic [Y_W-1:0]      vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                vga_plot
);

  state_t             state;
  logic [PHASE_W-1:0] phase;
  piece_t             shadow;
  piece_t             new_piece;
  logic               shadow_valid;
  logic               wdog_hit;
  piece_t             tet_piece;

  assign wdog_hit = (phase == PHASE_W'(WDOG_CYCLES));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= S_IDLE;
      phase        <= '0;
      ack          <= 1'b0;
      err          <= 1'b0;
      shadow       <= '0;
      new_piece    <= '0;
      shadow_valid <= 1'b0;
    end else begin
      ack <= 1'b0;
      if (!wdog_hit) phase <= phase + 1'b1;
      case (state)
        S_IDLE: begin
          if (board_req) begin
            state <= S_BOARD;
            phase <= '0;
            ack   <= 1'b1;
          end else if (piece_req) begin
            new_piece <= '{block: piece_block, rot: piece_rot, x: piece_x, y: piece_y};
            state     <= shadow_valid ? S_ERASE : S_DRAW;
            phase     <= '0;
            ack       <= 1'b1;
          end
        end
        S_BOARD: begin
          // A full redraw paints over whatever piece was on screen.
          if (brd_complete) begin
            state        <= S_FIN;
            phase        <= '0;
            shadow_valid <= 1'b0;
          end else if (wdog_hit) begin
            state <= S_FIN;
            phase <= '0;
            err   <= 1'b1;
          end
        end
        S_ERASE: begin
          if (tet_complete) begin
            state <= S_GAP;
            phase <= '0;
          end else if (wdog_hit) begin
            state <= S_FIN;
            phase <= '0;
            err   <= 1'b1;
          end
        end
        S_GAP: begin
          // One idle cycle lets the tetromino drawer re-arm its pixel counter.
          state <= S_DRAW;
          phase <= '0;
        end
        S_DRAW: begin
          if (tet_complete) begin
            shadow       <= new_piece;
            shadow_valid <= 1'b1;
            state        <= S_FIN;
            phase        <= '0;
          end else if (wdog_hit) begin
            state <= S_FIN;
            phase <= '0;
            err   <= 1'b1;
          end
        end
        S_FIN: begin
          state <= S_IDLE;
          phase <= '0;
        end
        default: begin
          state <= S_IDLE;
          phase <= '0;
        end
      endcase
    end
  end

  assign busy      = (state != S_IDLE);
  assign done      = (state == S_FIN);
  assign brd_en    = (state == S_BOARD);
  assign tet_en    = (state == S_ERASE) || (state == S_DRAW);
  assign tet_clear = (state == S_ERASE);

  always_comb begin
    tet_piece = '0;
    if (state == S_ERASE)     tet_piece = shadow;
    else if (state == S_DRAW) tet_piece = new_piece;
  end

  assign tet_block = tet_piece.block;
  assign tet_rot   = tet_piece.rot;
  assign tet_x     = tet_piece.x;
  assign tet_y     = tet_piece.y;

  draw_mux #(
    .TET_CYCLES (TET_CYCLES)
  ) u_mux (
    .state      (state),
    .phase      (phase),
    .brd_x      (brd_x),
    .brd_y      (brd_y),
    .brd_colour (brd_colour),
    .tet_vx     (tet_vx),
    .tet_vy     (tet_vy),
    .tet_colour (tet_colour),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot)
  );

endmodule

// File: tb/tb_draw_scheduler.sv
// Bench for draw_scheduler: simple drawer models feed the DUT, and a job-level model predicts every output cycle.
module tb_draw_scheduler;

  localparam int WDOG = 8191;
  localparam int TETN = 64;
  localparam int BPIX = 4000;

  typedef struct packed {
    logic [2:0] b;
    logic [1:0] r;
    logic [4:0] x;
    logic [5:0] y;
  } pc_t;

  typedef struct packed {
    logic       ack, busy, done, err, brd_en, tet_en, tet_clear, plot;
    pc_t        tp;
    logic [7:0] vx;
    logic [6:0] vy;
    logic [5:0] col;
  } obs_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic board_req = 1'b0, piece_req = 1'b0;
  logic [2:0] piece_block = '0;
  logic [1:0] piece_rot = '0;
  logic [4:0] piece_x = '0;
  logic [5:0] piece_y = '0;
  logic ack, busy, done, err, brd_en, tet_en, tet_clear, vga_plot;
  logic [7:0] brd_x = '0, tet_vx = '0, vga_x;
  logic [6:0] brd_y = '0, tet_vy = '0, vga_y;
  logic [5:0] brd_colour = '0, tet_colour = '0, vga_colour;
  logic brd_complete = 1'b0, tet_complete = 1'b0;
  logic [2:0] tet_block;
  logic [1:0] tet_rot;
  logic [4:0] tet_x;
  logic [5:0] tet_y;

  always #5 clk = ~clk;

  draw_scheduler dut (
    .clk(clk), .resetn(resetn), .board_req(board_req), .piece_req(piece_req),
    .piece_block(piece_block), .piece_rot(piece_rot), .piece_x(piece_x), .piece_y(piece_y),
    .ack(ack), .busy(busy), .done(done), .err(err), .brd_en(brd_en),
    .brd_x(brd_x), .brd_y(brd_y), .brd_colour(brd_colour), .brd_complete(brd_complete),
    .tet_en(tet_en), .tet_clear(tet_clear), .tet_block(tet_block), .tet_rot(tet_rot),
    .tet_x(tet_x), .tet_y(tet_y), .tet_vx(tet_vx), .tet_vy(tet_vy), .tet_colour(tet_colour),
    .tet_complete(tet_complete), .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .vga_plot(vga_plot)
  );

  obs_t dut_o;
  assign dut_o = {ack, busy, done, err, brd_en, tet_en, tet_clear, vga_plot,
                  tet_block, tet_rot, tet_x, tet_y, vga_x, vga_y, vga_colour};

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pixel patterns produced by the drawer models.
  function automatic logic [20:0] brd_pix(int k);
    return {8'(k % 40), 7'(k / 40), 6'(k % 63 + 1)};
  endfunction

  function automatic logic [20:0] tet_pix(pc_t p, int k, logic clr);
    logic [7:0] vx;
    logic [6:0] vy;
    logic [5:0] col;
    vx  = 8'(int'(p.x) * 4 + k % 4 + 4 * ((k / 16) % 2));
    vy  = 7'(int'(p.y) * 4 + (k / 4) % 4 + 4 * (k / 32));
    col = clr ? 6'd0 : {p.b, p.r, 1'b1};
    return {vx, vy, col};
  endfunction

  // Board drawer: registered output, one pixel per enabled cycle, level complete with last pixel.
  int bcnt = 0;
  always @(posedge clk) begin
    if (!brd_en) begin
      bcnt <= 0;
      {brd_x, brd_y, brd_colour} <= '0;
      brd_complete <= 1'b0;
    end else if (bcnt < BPIX) begin
      {brd_x, brd_y, brd_colour} <= brd_pix(bcnt);
      brd_complete <= (bcnt == BPIX - 1);
      bcnt <= bcnt + 1;
    end
  end

  // Tetromino drawer: 64 registered pixels then a complete pulse; can be stuck for watchdog tests.
  int tcnt = 0;
  logic tet_stuck = 1'b0;
  always @(posedge clk) begin
    if (!tet_en) begin
      tcnt <= 0;
      {tet_vx, tet_vy, tet_colour} <= '0;
      tet_complete <= 1'b0;
    end else begin
      tcnt <= tcnt + 1;
      if (tcnt < TETN) {tet_vx, tet_vy, tet_colour} <= tet_pix({tet_block, tet_rot, tet_x, tet_y}, tcnt, tet_clear);
      else             {tet_vx, tet_vy, tet_colour} <= '0;
      tet_complete <= (tcnt == TETN) && !tet_stuck;
    end
  end

  // Job-level model: expands each accepted job into the exact per-cycle output sequence.
  obs_t exp_q[$];
  logic m_err = 1'b0;
  logic m_sv = 1'b0;
  pc_t  m_sh = '0;
  logic chk_on = 1'b0;

  task automatic push_rec(logic a, logic bsy, logic dn, logic be, logic te, logic tc, logic pl,
                          pc_t pp, logic [20:0] v);
    exp_q.push_back({a, bsy, dn, m_err, be, te, tc, pl, pp, v});
  endtask

  task automatic push_idle();
    push_rec(0, 0, 0, 0, 0, 0, 0, '0, '0);
  endtask

  task automatic model_board(output int len);
    push_rec(1, 1, 0, 1, 0, 0, 0, '0, '0);
    for (int k = 1; k <= BPIX; k++) push_rec(0, 1, 0, 1, 0, 0, 1, '0, brd_pix(k - 1));
    m_sv = 1'b0;
    push_rec(0, 1, 1, 0, 0, 0, 0, '0, '0);
    len = BPIX + 2;
  endtask

  task automatic push_pass(pc_t pp, logic clr, logic ack_first, logic stuck, inout int len);
    int last;
    last = stuck ? WDOG : TETN + 1;
    for (int ph = 0; ph <= last; ph++) begin
      logic pl;
      pl = (ph >= 1) && (ph <= TETN);
      push_rec(ack_first && (ph == 0), 1, 0, 0, 1, clr, pl, pp, pl ? tet_pix(pp, ph - 1, clr) : 21'd0);
      len++;
    end
  endtask

  task automatic model_piece(pc_t n, logic stuck, output int len);
    logic first;
    len = 0;
    first = 1'b1;
    if (m_sv) begin
      push_pass(m_sh, 1'b1, 1'b1, stuck, len);
      first = 1'b0;
      if (stuck) begin
        m_err = 1'b1;
        push_rec(0, 1, 1, 0, 0, 0, 0, '0, '0);
        len++;
        return;
      end
      push_rec(0, 1, 0, 0, 0, 0, 0, '0, '0);
      len++;
    end
    push_pass(n, 1'b0, first, stuck, len);
    if (stuck) m_err = 1'b1;
    else begin
      m_sh = n;
      m_sv = 1'b1;
    end
    push_rec(0, 1, 1, 0, 0, 0, 0, '0, '0);
    len++;
  endtask

  // Single per-cycle compare against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      obs_t e;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL cyc=%0d model_queue_empty got=%h", cyc, dut_o);
      end else begin
        e = exp_q.pop_front();
        if (dut_o !== e) begin
          bad++;
          $display("FAIL cyc=%0d outputs got=%h want=%h", cyc, dut_o, e);
        end
      end
    end
  end

  // Per-job statistics for the hand-computed expectations.
  int st_t0, st_ack, st_done, st_ndone, st_plot, st_plot0, st_gap, st_fx, st_dx;
  int st_xmin, st_xmax, st_ymin, st_ymax;
  always @(negedge clk) begin
    if (ack && st_ack < 0) st_ack = cyc - st_t0;
    if (done) begin
      st_done = cyc - st_t0;
      st_ndone++;
    end
    if (busy && !tet_en && !brd_en && !done) st_gap++;
    if (vga_plot) begin
      st_plot++;
      if (vga_colour == 0) begin
        st_plot0++;
        if (st_fx < 0) st_fx = int'(vga_x);
      end else if (st_dx < 0) st_dx = int'(vga_x);
      if (int'(vga_x) < st_xmin) st_xmin = int'(vga_x);
      if (int'(vga_x) > st_xmax) st_xmax = int'(vga_x);
      if (int'(vga_y) < st_ymin) st_ymin = int'(vga_y);
      if (int'(vga_y) > st_ymax) st_ymax = int'(vga_y);
    end
  end

  task automatic stat_clear();
    st_t0 = cyc; st_ack = -1; st_done = -1; st_ndone = 0; st_plot = 0; st_plot0 = 0;
    st_gap = 0; st_fx = -1; st_dx = -1;
    st_xmin = 999; st_xmax = -1; st_ymin = 999; st_ymax = -1;
  endtask

  task automatic chk(string name, longint got, longint want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic pc_t rand_pc();
    pc_t p;
    p.b = 3'($urandom_range(0, 7));
    p.r = 2'($urandom_range(0, 3));
    p.x = 5'($urandom_range(0, 31));
    p.y = 6'($urandom_range(0, 63));
    return p;
  endfunction

  task automatic set_piece(pc_t p);
    {piece_block, piece_rot, piece_x, piece_y} = p;
  endtask

  task automatic idle_cycles(int n);
    repeat (n) begin
      push_idle();
      next_cycle();
    end
  endtask

  task automatic run_board();
    int len;
    board_req = 1'b1;
    push_idle();
    model_board(len);
    next_cycle();
    board_req = 1'b0;
    repeat (len) next_cycle();
  endtask

  task automatic run_piece(pc_t p);
    int len;
    set_piece(p);
    piece_req = 1'b1;
    push_idle();
    model_piece(p, tet_stuck, len);
    next_cycle();
    piece_req = 1'b0;
    set_piece(rand_pc());
    repeat (len) next_cycle();
  endtask

  task automatic run_both(pc_t p);
    int l1, l2;
    set_piece(p);
    board_req = 1'b1;
    piece_req = 1'b1;
    push_idle();
    model_board(l1);
    push_idle();
    model_piece(p, 1'b0, l2);
    next_cycle();
    board_req = 1'b0;
    repeat (l1 + 1) next_cycle();
    piece_req = 1'b0;
    set_piece(rand_pc());
    repeat (l2) next_cycle();
  endtask

  task automatic reset_mid_draw();
    bit found;
    chk_on = 1'b0;
    set_piece(rand_pc());
    piece_req = 1'b1;
    next_cycle();
    piece_req = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      if (tet_en && !tet_clear) found = 1'b1;
      else next_cycle();
    end
    chk("reach_draw_before_reset", found, 1);
    repeat (20) next_cycle();
    #2 resetn = 1'b0;
    #1 chk("async_reset_outputs", longint'(dut_o), 0);
    next_cycle();
    chk("no_done_in_reset", done, 0);
    next_cycle();
    resetn = 1'b1;
    m_err = 1'b0;
    m_sv = 1'b0;
    chk_on = 1'b1;
  endtask

  initial begin
    stat_clear();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", longint'(dut_o), 0);
    resetn = 1'b1;
    chk_on = 1'b1;
    idle_cycles(2);

    stat_clear();
    run_board();
    chk("board_ack_latency", st_ack, 1);
    chk("board_done_latency", st_done, 4002);
    chk("board_plots", st_plot, 4000);
    chk("board_xmin", st_xmin, 0);
    chk("board_xmax", st_xmax, 39);
    chk("board_ymin", st_ymin, 0);
    chk("board_ymax", st_ymax, 99);

    stat_clear();
    run_piece('{b: 3'd3, r: 2'd1, x: 5'd4, y: 6'd2});
    chk("piece1_done_latency", st_done, 67);
    chk("piece1_plots", st_plot, 64);
    chk("piece1_zero_colour_plots", st_plot0, 0);
    chk("piece1_gap", st_gap, 0);

    stat_clear();
    run_piece('{b: 3'd3, r: 2'd1, x: 5'd5, y: 6'd2});
    chk("piece2_plots", st_plot, 128);
    chk("piece2_erase_plots", st_plot0, 64);
    chk("piece2_gap", st_gap, 1);
    chk("piece2_done_latency", st_done, 134);
    chk("piece2_erase_first_x", st_fx, 16);
    chk("piece2_draw_first_x", st_dx, 20);

    stat_clear();
    run_both('{b: 3'd2, r: 2'd3, x: 5'd7, y: 6'd9});
    chk("both_first_ack", st_ack, 1);
    chk("both_done_count", st_ndone, 2);
    chk("both_piece_done_latency", st_done, 4070);

    for (int i = 0; i < 40; i++) begin
      int r;
      idle_cycles($urandom_range(0, 3));
      r = $urandom_range(0, 29);
      if (r == 0)      run_both(rand_pc());
      else if (r == 1) run_board();
      else             run_piece(rand_pc());
    end

    run_piece(rand_pc());
    stat_clear();
    tet_stuck = 1'b1;
    run_piece(rand_pc());
    tet_stuck = 1'b0;
    chk("wdog_err", err, 1);
    chk("wdog_done_latency", st_done, 8193);
    chk("wdog_erase_plots", st_plot0, 64);
    stat_clear();
    run_piece(rand_pc());
    chk("after_wdog_gap", st_gap, 1);

    reset_mid_draw();
    stat_clear();
    run_piece(rand_pc());
    chk("after_reset_gap", st_gap, 0);
    chk("after_reset_done_latency", st_done, 67);
    idle_cycles(3);

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
